// File: rtl/seq_detect_fsm.sv
// ============================================================================
// Module   : seq_detect_fsm
// Brief    : Parametrised serial pattern detector with overlap control and an
//            optional saturating match counter (enabled by SEQDET_COUNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_fsm #(
  parameter int             PW      = 4,
  parameter logic [PW-1:0]  PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          x,
  input  logic          clr,
  output logic          match,
  output logic [1:0]    state,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam int             FW     = $clog2(PW + 1);
  localparam logic [FW-1:0]  C_FULL = FW'(PW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_ARMED = 2'b10
  } state_t;

  state_t          r_state;
  logic            r_match;
  logic [FW-1:0]   r_fill;
  // Only the newest PW-1 bits are kept: the oldest bit is shifted out on
  // the same edge the comparison window is formed, so it is never needed.
  logic [PW-2:0]   r_hist;

  logic [PW-1:0]   w_window;
  logic [FW-1:0]   w_fill_next;
  logic            w_hit;

  assign w_window    = {r_hist, x};
  assign w_fill_next = (r_fill == C_FULL) ? C_FULL : r_fill + FW'(1);
  assign w_hit       = en && !clr && (w_fill_next == C_FULL) && (w_window == PATTERN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_state <= ST_IDLE;
      r_match <= 1'b0;
    end else if (clr) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_state <= ST_IDLE;
      r_match <= 1'b0;
    end else if (en) begin
      r_hist  <= w_window[PW-2:0];
      r_match <= w_hit;
      if (w_hit && !OVERLAP) begin
        r_fill  <= '0;
        r_state <= ST_IDLE;
      end else begin
        r_fill  <= w_fill_next;
        r_state <= (w_fill_next == C_FULL) ? ST_ARMED : ST_FILL;
      end
    end else begin
      r_match <= 1'b0;
    end
  end

  assign match = r_match;
  assign state = r_state;

`ifdef SEQDET_COUNT_EN
  localparam logic [CW-1:0] C_CNT_MAX = '1;

  logic [CW-1:0] r_count;
  logic          r_ovf;

  // The hit that would wrap leaves the count pinned and raises the sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (w_hit) begin
      if (r_count == C_CNT_MAX) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;
`else
  assign count = '0;
  assign ovf   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_fsm.sv
// ============================================================================
// Module   : tb_seq_detect_fsm
// Brief    : Self-checking bench for seq_detect_fsm; overlap and non-overlap
//            instances (CW=2) driven in parallel from one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detect_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       x   = 1'b0;
  logic       clr = 1'b0;

  logic       m_ov, m_no, v_ov, v_no;
  logic [1:0] s_ov, s_no, c_ov, c_no;

`ifdef SEQDET_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  seq_detect_fsm #(.PW(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CW(2)) u_ov (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
    .match(m_ov), .state(s_ov), .count(c_ov), .ovf(v_ov)
  );

  seq_detect_fsm #(.PW(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CW(2)) u_no (
    .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
    .match(m_no), .state(s_no), .count(c_no), .ovf(v_no)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       x;
    logic       clr;
    logic       m_ov;
    logic [1:0] s_ov;
    logic       m_no;
    logic [1:0] s_no;
  } vec_t;

  typedef struct {
    logic       m_ov;
    logic [1:0] s_ov;
    logic [1:0] c_ov;
    logic       v_ov;
    logic       m_no;
    logic [1:0] s_no;
    logic [1:0] c_no;
    logic       v_no;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Expected counter contents, advanced from the expected hit flags.
  int   cnt_ov = 0;
  int   cnt_no = 0;
  logic ovf_ov = 1'b0;
  logic ovf_no = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".match_ov"}, 32'(m_ov), 32'(e.m_ov));
    chk({tag, ".state_ov"}, 32'(s_ov), 32'(e.s_ov));
    chk({tag, ".count_ov"}, 32'(c_ov), 32'(e.c_ov));
    chk({tag, ".ovf_ov"},   32'(v_ov), 32'(e.v_ov));
    chk({tag, ".match_no"}, 32'(m_no), 32'(e.m_no));
    chk({tag, ".state_no"}, 32'(s_no), 32'(e.s_no));
    chk({tag, ".count_no"}, 32'(c_no), 32'(e.c_no));
    chk({tag, ".ovf_no"},   32'(v_no), 32'(e.v_no));
  endtask

  task automatic clear_model();
    cnt_ov = 0; cnt_no = 0; ovf_ov = 1'b0; ovf_no = 1'b0;
  endtask

  // Drive one cycle, push the expectation, pop and compare after the edge.
  task automatic step(input string tag, input logic i_en, input logic i_x, input logic i_clr,
                      input logic em_ov, input logic [1:0] es_ov,
                      input logic em_no, input logic [1:0] es_no);
    exp_t e;
    en  = i_en;
    x   = i_x;
    clr = i_clr;
    if (i_clr) begin
      clear_model();
    end else begin
      if (em_ov) begin
        if (cnt_ov == 3) ovf_ov = 1'b1; else cnt_ov++;
      end
      if (em_no) begin
        if (cnt_no == 3) ovf_no = 1'b1; else cnt_no++;
      end
    end
    e.m_ov = em_ov;
    e.s_ov = es_ov;
    e.c_ov = CNT_ON ? 2'(cnt_ov) : 2'd0;
    e.v_ov = CNT_ON ? ovf_ov : 1'b0;
    e.m_no = em_no;
    e.s_no = es_no;
    e.c_no = CNT_ON ? 2'(cnt_no) : 2'd0;
    e.v_no = CNT_ON ? ovf_no : 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_all(tag, sb.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[8];
    exp_t       zero_e;
    logic [3:0] pat;
    logic [15:0] s6;
    logic [3:0] win;
    int         fno;
    logic       b, hov, hno;
    logic [1:0] sov, sno;

    zero_e = '{1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0};

    // OVERLAP=1 / OVERLAP=0 on stream 1,0,1,1,0,1,1 then one idle cycle
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 2'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd1};

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", zero_e);
    rst = 1'b1;

    foreach (tbl[i])
      step("tbl", tbl[i].en, tbl[i].x, tbl[i].clr, tbl[i].m_ov, tbl[i].s_ov, tbl[i].m_no, tbl[i].s_no);

    // Gapped enable: history survives idle cycles, x ignored while en=0
    pat = 4'b1011;
    step("gap_clr", 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        step("gap_bit", 1'b1, pat[3-k], 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
        for (int g = 0; g < 3; g++)
          step("gap_idle", 1'b0, 1'($urandom_range(1, 0)), 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
      end else begin
        step("gap_hit", 1'b1, pat[3-k], 1'b0, 1'b1, 2'd2, 1'b1, 2'd0);
      end
    end
    step("gap_after", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0);

    // Asynchronous reset mid-cycle after 1,0,1
    step("ar_clr", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    step("ar_b1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
    step("ar_b2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
    step("ar_b3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
    en = 1'b0;
    #2 rst = 1'b0;
    #1;
    clear_model();
    check_all("async_rst", zero_e);
    #1 rst = 1'b1;
    step("ar_after", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);

    // clr wins over en on the 4th bit; the full pattern is then needed again
    step("cl_clr", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    step("cl_b1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
    step("cl_b2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
    step("cl_b3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
    step("cl_b4clr", 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    step("cl_r1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
    step("cl_r2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
    step("cl_r3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1);
    step("cl_r4", 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 2'd0);

    // Counter saturation: 5 overlapping hits, 3 non-overlapping hits
    step("cnt_clr", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);
    s6  = 16'b1011011011011011;
    win = 4'b0000;
    fno = 0;
    for (int i = 1; i <= 16; i++) begin
      b   = s6[16-i];
      win = {win[2:0], b};
      hov = (i >= 4) && (win == 4'b1011);
      sov = (i < 4) ? 2'd1 : 2'd2;
      fno = (fno < 4) ? fno + 1 : 4;
      hno = (fno == 4) && (win == 4'b1011);
      if (hno) fno = 0;
      sno = (fno == 0) ? 2'd0 : ((fno < 4) ? 2'd1 : 2'd2);
      step("cnt", 1'b1, b, 1'b0, hov, sov, hno, sno);
    end
    step("cnt_idle", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0);
    step("cnt_clr2", 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
